// File: rtl/alu_writeback_stage_pkg.sv
// Shared ARM-style constants for the ALU writeback stage: condition codes,
// ALU opcodes, NZCV bit positions, PC index and writeback FSM states.
package alu_writeback_stage_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned REG_W  = 4;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // ALU data-processing opcodes
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Bit positions inside {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] PC_IDX = 4'd15;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

endpackage

// File: rtl/alu_writeback_stage_cond_check.sv
// Combinational ARM condition evaluator: {cond, nzcv} -> pass.
module cond_check
    import alu_writeback_stage_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass_c
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[FLAG_N];
    assign w_z = i_nzcv[FLAG_Z];
    assign w_c = i_nzcv[FLAG_C];
    assign w_v = i_nzcv[FLAG_V];

    // Decode the condition field against the current flags
    always_comb begin
        o_pass_c = 1'b0;
        case (i_cond)
            COND_EQ: o_pass_c = w_z;
            COND_NE: o_pass_c = ~w_z;
            COND_CS: o_pass_c = w_c;
            COND_CC: o_pass_c = ~w_c;
            COND_MI: o_pass_c = w_n;
            COND_PL: o_pass_c = ~w_n;
            COND_VS: o_pass_c = w_v;
            COND_VC: o_pass_c = ~w_v;
            COND_HI: o_pass_c = w_c & ~w_z;
            COND_LS: o_pass_c = ~w_c | w_z;
            COND_GE: o_pass_c = (w_n == w_v);
            COND_LT: o_pass_c = (w_n != w_v);
            COND_GT: o_pass_c = ~w_z & (w_n == w_v);
            COND_LE: o_pass_c = w_z | (w_n != w_v);
            COND_AL: o_pass_c = 1'b1;
            default: o_pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: condition-gated commit of ALU result and NZCV,
// register-file write port, PC redirect on rd==15 and post-branch flush.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter logic [3:0]  FLAGS_RST   = 4'b0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_nzcv,
    input  logic              in_result_wb,
    input  logic              in_nzcv_wb,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_cond,
    output logic              rf_valid,
    input  logic              rf_ready,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              branch_valid,
    output logic [DATA_W-1:0] branch_target,
    output logic              flushing,
    output logic [3:0]        cpsr_flags
);

    localparam int unsigned CNT_W = $clog2(FLUSH_DEPTH + 1);

    wb_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]        r_flags, w_flags_nxt;
    logic              r_rf_valid, w_rf_valid_nxt;
    logic [3:0]        r_waddr, w_waddr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_bv, w_bv_nxt;
    logic [DATA_W-1:0] r_bt, w_bt_nxt;
    logic              w_fire;
    logic              w_pass;

    assign in_ready = ~r_rf_valid | rf_ready;
    assign w_fire   = in_valid & in_ready;

    cond_check u_cond_check (
        .i_cond   (in_cond),
        .i_nzcv   (r_flags),
        .o_pass_c (w_pass)
    );

    // Next-state and next-output logic; a loaded write overrides completion
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_flags_nxt    = r_flags;
        w_rf_valid_nxt = r_rf_valid & ~rf_ready;
        w_waddr_nxt    = r_waddr;
        w_wdata_nxt    = r_wdata;
        w_bv_nxt       = 1'b0;
        w_bt_nxt       = r_bt;
        case (r_state)
            ST_RUN: begin
                if (w_fire && w_pass) begin
                    if (in_nzcv_wb) begin
                        w_flags_nxt = in_nzcv;
                    end
                    if (in_result_wb) begin
                        if (in_rd == PC_IDX) begin
                            w_bv_nxt    = 1'b1;
                            w_bt_nxt    = {in_result[DATA_W-1:2], 2'b00};
                            w_state_nxt = ST_FLUSH;
                            w_cnt_nxt   = CNT_W'(FLUSH_DEPTH);
                        end else begin
                            w_rf_valid_nxt = 1'b1;
                            w_waddr_nxt    = in_rd;
                            w_wdata_nxt    = in_result;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (w_fire) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_flags    <= FLAGS_RST;
            r_rf_valid <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_bv       <= 1'b0;
            r_bt       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flags    <= w_flags_nxt;
            r_rf_valid <= w_rf_valid_nxt;
            r_waddr    <= w_waddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_bv       <= w_bv_nxt;
            r_bt       <= w_bt_nxt;
        end
    end

    assign rf_valid      = r_rf_valid;
    assign rf_waddr      = r_waddr;
    assign rf_wdata      = r_wdata;
    assign branch_valid  = r_bv;
    assign branch_target = r_bt;
    assign flushing      = (r_state == ST_FLUSH);
    assign cpsr_flags    = r_flags;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios followed by random beats,
// all checked every cycle against a transaction-level model of the stage.
module tb_alu_writeback_stage;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [3:0]    in_nzcv;
    logic          in_result_wb;
    logic          in_nzcv_wb;
    logic [3:0]    in_rd;
    logic [3:0]    in_cond;
    logic          rf_valid;
    logic          rf_ready;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          branch_valid;
    logic [DW-1:0] branch_target;
    logic          flushing;
    logic [3:0]    cpsr_flags;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [3:0]    m_flags;
    int            m_drop;
    logic          m_rfv;
    logic [3:0]    m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_bv;
    logic [DW-1:0] m_bt;

    alu_writeback_stage #(
        .DATA_W      (DW),
        .FLUSH_DEPTH (DEPTH),
        .FLAGS_RST   (4'b0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_nzcv       (in_nzcv),
        .in_result_wb  (in_result_wb),
        .in_nzcv_wb    (in_nzcv_wb),
        .in_rd         (in_rd),
        .in_cond       (in_cond),
        .rf_valid      (rf_valid),
        .rf_ready      (rf_ready),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .flushing      (flushing),
        .cpsr_flags    (cpsr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ARM condition semantics written from the mnemonic table
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000; m_drop = 0; m_rfv = 1'b0; m_waddr = '0;
        m_wdata = '0; m_bv = 1'b0; m_bt = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rf_valid"}, DW'(rf_valid), DW'(m_rfv));
        chk({tag, ".rf_waddr"}, DW'(rf_waddr), DW'(m_waddr));
        chk({tag, ".rf_wdata"}, rf_wdata, m_wdata);
        chk({tag, ".branch_valid"}, DW'(branch_valid), DW'(m_bv));
        chk({tag, ".branch_target"}, branch_target, m_bt);
        chk({tag, ".flushing"}, DW'(flushing), DW'(m_drop != 0));
        chk({tag, ".cpsr"}, DW'(cpsr_flags), DW'(m_flags));
    endtask

    // Drive one beat for one cycle, then advance the model and compare
    task automatic step(input string tag, input logic v, input logic [DW-1:0] res,
                        input logic [3:0] nzcv, input logic rwb, input logic nwb,
                        input logic [3:0] rd, input logic [3:0] cond, input logic rfr);
        bit fire, pass;
        in_valid = v; in_result = res; in_nzcv = nzcv; in_result_wb = rwb;
        in_nzcv_wb = nwb; in_rd = rd; in_cond = cond; rf_ready = rfr;
        #1;
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(!m_rfv || rfr));
        fire = v && (!m_rfv || rfr);
        pass = cond_ok(cond, m_flags);
        @(posedge clk);
        if (rfr) m_rfv = 1'b0;
        m_bv = 1'b0;
        if (fire) begin
            if (m_drop > 0) begin
                m_drop--;
            end else if (pass) begin
                if (nwb) m_flags = nzcv;
                if (rwb && rd == 4'd15) begin
                    m_bv = 1'b1; m_bt = res & ~DW'(3); m_drop = DEPTH;
                end else if (rwb) begin
                    m_rfv = 1'b1; m_waddr = rd; m_wdata = res;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hE, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] held;
        reset_n = 1'b0;
        model_reset();
        in_valid = 1'b1; in_result = 32'hDEADBEEF; in_nzcv = 4'hF; in_result_wb = 1'b1;
        in_nzcv_wb = 1'b1; in_rd = 4'd1; in_cond = 4'hE; rf_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rf_valid", DW'(rf_valid), '0);
        chk("rst.branch_valid", DW'(branch_valid), '0);
        chk("rst.flushing", DW'(flushing), '0);
        chk("rst.cpsr", DW'(cpsr_flags), '0);
        check_all("rst");
        reset_n = 1'b1;

        // Flag-setting add to r3
        step("add", 1'b1, 32'h10, 4'b0110, 1'b1, 1'b1, 4'd3, 4'hE, 1'b1);
        chk("add.cpsr_const", DW'(cpsr_flags), DW'(4'b0110));
        chk("add.waddr_const", DW'(rf_waddr), DW'(3));
        chk("add.wdata_const", rf_wdata, 32'h10);

        // Taken BEQ to PC, then two dropped beats, third written
        step("beq", 1'b1, 32'h103, 4'h0, 1'b1, 1'b0, 4'd15, 4'h0, 1'b1);
        chk("beq.bv_const", DW'(branch_valid), DW'(1));
        chk("beq.target_const", branch_target, 32'h100);
        step("drop1", 1'b1, 32'h55, 4'hF, 1'b1, 1'b1, 4'd5, 4'hE, 1'b1);
        chk("drop1.bv_const", DW'(branch_valid), '0);
        step("drop2", 1'b1, 32'h66, 4'hF, 1'b1, 1'b1, 4'd15, 4'hE, 1'b1);
        step("after", 1'b1, 32'h77, 4'h0, 1'b1, 1'b0, 4'd6, 4'hE, 1'b1);
        chk("after.waddr_const", DW'(rf_waddr), DW'(6));
        chk("after.rfv_const", DW'(rf_valid), DW'(1));

        // Failing NE with Z set, and NV, never commit
        step("ne_fail", 1'b1, 32'hAA, 4'hF, 1'b1, 1'b1, 4'd7, 4'h1, 1'b1);
        chk("ne_fail.cpsr_const", DW'(cpsr_flags), DW'(4'b0110));
        chk("ne_fail.rfv_const", DW'(rf_valid), '0);
        step("nv", 1'b1, 32'hBB, 4'hF, 1'b1, 1'b1, 4'd8, 4'hF, 1'b1);

        // Register-file backpressure for three cycles
        step("stall_ld", 1'b1, 32'h1234, 4'h0, 1'b1, 1'b0, 4'd2, 4'hE, 1'b0);
        held = rf_wdata;
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 32'h9999, 4'h0, 1'b1, 1'b0, 4'd9, 4'hE, 1'b0);
            chk("stall.in_ready_const", DW'(in_ready), '0);
            chk("stall.hold", rf_wdata, held);
        end
        step("release", 1'b0, '0, 4'h0, 1'b0, 1'b0, 4'd0, 4'hE, 1'b1);

        // Reset asserted with one beat left to drop
        step("br2", 1'b1, 32'h2000, 4'h0, 1'b1, 1'b0, 4'd15, 4'hE, 1'b1);
        step("drop_a", 1'b1, 32'h1, 4'h0, 1'b1, 1'b0, 4'd1, 4'hE, 1'b1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.flushing_const", DW'(flushing), '0);
        check_all("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("post_rst", 1'b1, 32'h44, 4'h0, 1'b1, 1'b0, 4'd4, 4'hE, 1'b1);
        chk("post_rst.rfv_const", DW'(rf_valid), DW'(1));
        chk("post_rst.waddr_const", DW'(rf_waddr), DW'(4));

        // Random beats
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), rd,
                 4'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        idle("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
